// File: rtl/sata_identify_ctrl_pkg.sv
// rtl/sata_identify_ctrl_pkg.sv - shared SATA FIS type and ATA command codes, H2D command FIS builder
package sata_identify_ctrl_pkg;

  localparam logic [7:0]  REG_H2D_FIS      = 8'h27;
  localparam logic [7:0]  REG_D2H_FIS      = 8'h34;
  localparam logic [7:0]  ATA_CMD_IDENTIFY = 8'hEC;
  localparam int unsigned H2D_FIS_DWORDS   = 5;

  typedef logic [H2D_FIS_DWORDS-1:0][31:0] h2d_fis_t;

  // Byte 1 bit 7 is the C bit: this FIS carries a new command
  function automatic h2d_fis_t build_h2d_cmd(input logic [7:0] cmd);
    h2d_fis_t fis;
    fis    = '0;
    fis[0] = {8'h00, cmd, 8'h80, REG_H2D_FIS};
    return fis;
  endfunction

endpackage

// File: rtl/sata_h2d_fis_tx.sv
// rtl/sata_h2d_fis_tx.sv - 5-dword H2D FIS sequencer; dword/eop held while valid and not ready
module sata_h2d_fis_tx
  import sata_identify_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_abort,
  input  h2d_fis_t    i_fis,
  output logic [31:0] o_dat,
  output logic        o_val,
  output logic        o_eop,
  input  logic        i_rdy,
  output logic        o_done
);

  localparam logic [2:0] LAST_IDX = 3'(H2D_FIS_DWORDS - 1);

  logic [2:0]  r_idx;
  logic [31:0] r_dat;
  logic        r_val;
  logic        r_eop;
  logic        w_accept;
  logic [2:0]  w_next_idx;

  assign w_accept   = r_val && i_rdy;
  assign w_next_idx = r_idx + 3'd1;

  // Abort outranks start so a link drop always silences the stream
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx <= '0;
      r_dat <= '0;
      r_val <= 1'b0;
      r_eop <= 1'b0;
    end else if (i_abort) begin
      r_idx <= '0;
      r_dat <= '0;
      r_val <= 1'b0;
      r_eop <= 1'b0;
    end else if (i_start) begin
      r_idx <= '0;
      r_dat <= i_fis[0];
      r_val <= 1'b1;
      r_eop <= 1'b0;
    end else if (w_accept) begin
      if (r_eop) begin
        r_idx <= '0;
        r_dat <= '0;
        r_val <= 1'b0;
        r_eop <= 1'b0;
      end else begin
        r_idx <= w_next_idx;
        r_dat <= i_fis[w_next_idx];
        r_eop <= (w_next_idx == LAST_IDX);
      end
    end
  end

  assign o_dat  = r_dat;
  assign o_val  = r_val;
  assign o_eop  = r_eop;
  assign o_done = w_accept && r_eop;

endmodule

// File: rtl/sata_identify_ctrl.sv
// rtl/sata_identify_ctrl.sv - IDENTIFY DEVICE sequencer: send H2D 0xEC, await parser result, retry
// Optional SATA_IDENTIFY_AUTOSTART_EN: a rising edge of link_ready also launches IDENTIFY.
module sata_identify_ctrl
  import sata_identify_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             link_ready,
  input  logic                             start,
  output logic [31:0]                      o_dat,
  output logic                             o_val,
  output logic                             o_eop,
  input  logic                             o_rdy,
  input  logic [31:0]                      i_dat,
  input  logic                             i_val,
  input  logic                             i_eop,
  input  logic                             id_done,
  input  logic                             id_bad_crc,
  output logic                             busy,
  output logic                             identify_ok,
  output logic                             identify_fail,
  output logic [$clog2(MAX_RETRIES+2)-1:0] attempt_cnt
);

  localparam int CNT_W = $clog2(MAX_RETRIES + 2);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_DONE, S_FAIL} state_e;

  state_e           r_state;
  logic             r_busy, r_ok, r_fail;
  logic             r_done_q, r_bad_q, r_sof;
  logic [CNT_W-1:0] r_attempt;
  logic [TO_W-1:0]  r_to_cnt;

  logic     w_auto, w_idle_like, w_active, w_launch;
  logic     w_done_rise, w_d2h_err, w_err, w_timeout;
  logic     w_retry, w_can_retry, w_tx_start, w_tx_abort, w_tx_done;
  logic     w_unused;
  h2d_fis_t w_fis;

`ifdef SATA_IDENTIFY_AUTOSTART_EN
  logic r_link_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_link_q <= 1'b0;
    else       r_link_q <= link_ready;
  end
  assign w_auto = link_ready && !r_link_q;
`else
  assign w_auto = 1'b0;
`endif

  assign w_fis       = build_h2d_cmd(ATA_CMD_IDENTIFY);
  assign w_unused    = &{1'b0, i_dat[31:17], i_dat[15:8]};
  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_FAIL);
  assign w_active    = (r_state == S_SEND) || (r_state == S_WAIT);
  assign w_launch    = w_idle_like && link_ready && (start || w_auto);
  assign w_done_rise = id_done && !r_done_q;
  assign w_d2h_err   = i_val && r_sof && (i_dat[7:0] == REG_D2H_FIS) && i_dat[16];
  assign w_err       = (id_bad_crc && !r_bad_q) || w_d2h_err;
  assign w_timeout   = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  // An error outranks a same-cycle success; a success outranks the timeout
  assign w_retry     = (r_state == S_WAIT) && link_ready && (w_err || (w_timeout && !w_done_rise));
  assign w_can_retry = (r_attempt <= CNT_W'(MAX_RETRIES));
  assign w_tx_start  = w_launch || (w_retry && w_can_retry);
  assign w_tx_abort  = w_active && !link_ready;

  sata_h2d_fis_tx u_fis_tx (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_tx_start),
    .i_abort (w_tx_abort),
    .i_fis   (w_fis),
    .o_dat   (o_dat),
    .o_val   (o_val),
    .o_eop   (o_eop),
    .i_rdy   (o_rdy),
    .o_done  (w_tx_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_ok      <= 1'b0;
      r_fail    <= 1'b0;
      r_done_q  <= 1'b0;
      r_bad_q   <= 1'b0;
      r_sof     <= 1'b1;
      r_attempt <= '0;
      r_to_cnt  <= '0;
    end else begin
      r_done_q <= id_done;
      r_bad_q  <= id_bad_crc;
      if (i_val) r_sof <= i_eop;
      case (r_state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (w_launch) begin
            r_state   <= S_SEND;
            r_busy    <= 1'b1;
            r_ok      <= 1'b0;
            r_fail    <= 1'b0;
            r_attempt <= CNT_W'(1);
          end
        end
        S_SEND: begin
          if (!link_ready) begin
            r_state <= S_FAIL;
            r_busy  <= 1'b0;
            r_fail  <= 1'b1;
          end else if (w_tx_done) begin
            r_state  <= S_WAIT;
            r_to_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (!link_ready) begin
            r_state <= S_FAIL;
            r_busy  <= 1'b0;
            r_fail  <= 1'b1;
          end else if (w_retry) begin
            r_to_cnt <= '0;
            if (w_can_retry) begin
              r_state   <= S_SEND;
              r_attempt <= r_attempt + CNT_W'(1);
            end else begin
              r_state <= S_FAIL;
              r_busy  <= 1'b0;
              r_fail  <= 1'b1;
            end
          end else if (w_done_rise) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_ok    <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy          = r_busy;
  assign identify_ok   = r_ok;
  assign identify_fail = r_fail;
  assign attempt_cnt   = r_attempt;

endmodule

// File: tb/tb_sata_identify_ctrl.sv
// tb/tb_sata_identify_ctrl.sv - self-checking bench for sata_identify_ctrl
module tb_sata_identify_ctrl;

  localparam int TO = 100;
  localparam int MR = 2;
  localparam int AW = $clog2(MR + 2);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          link_ready = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   o_dat;
  logic          o_val, o_eop;
  logic          rdy = 1'b1;
  logic [31:0]   i_dat = '0;
  logic          i_val = 1'b0, i_eop = 1'b0;
  logic          id_done = 1'b0, id_bad_crc = 1'b0;
  logic          busy, identify_ok, identify_fail;
  logic [AW-1:0] attempt_cnt;

  sata_identify_ctrl #(.TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR)) dut (
    .clk           (clk),
    .reset         (reset),
    .link_ready    (link_ready),
    .start         (start),
    .o_dat         (o_dat),
    .o_val         (o_val),
    .o_eop         (o_eop),
    .o_rdy         (rdy),
    .i_dat         (i_dat),
    .i_val         (i_val),
    .i_eop         (i_eop),
    .id_done       (id_done),
    .id_bad_crc    (id_bad_crc),
    .busy          (busy),
    .identify_ok   (identify_ok),
    .identify_fail (identify_fail),
    .attempt_cnt   (attempt_cnt)
  );

  always #5 clk = ~clk;

  typedef enum int {R_DONE, R_NONE, R_D2H, R_BAD, R_BOTH} resp_e;
  typedef struct {
    bit    toggle;
    resp_e resp;
    int    delay;
    bit    exp_ok;
    bit    exp_fail;
    int    exp_att;
  } vec_t;
  typedef struct {
    logic [31:0] dat;
    logic        eop;
  } beat_t;

  int    checks = 0;
  int    errors = 0;
  bit    rdy_mode = 1'b0;
  beat_t qexp[$];
  int    gaps[$];
  int    cyc = 0, eop_cnt = 0, t_eop = 0;
  bit    eop_seen = 1'b0;
  vec_t  vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fis();
    qexp.push_back('{32'h00EC_8027, 1'b0});
    qexp.push_back('{32'h0, 1'b0});
    qexp.push_back('{32'h0, 1'b0});
    qexp.push_back('{32'h0, 1'b0});
    qexp.push_back('{32'h0, 1'b1});
  endtask

  task automatic do_start();
    step();
    start = 1'b1;
    push_fis();
    step();
    start = 1'b0;
  endtask

  task automatic wait_eop(input int n);
    for (int i = 0; i < 400 && eop_cnt < n; i++) step();
    chk("eop_count", eop_cnt, n);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && busy; i++) step();
    chk("busy_drop", 32'(busy), 32'd0);
  endtask

  // Transport-side ready: steady high, or toggling every cycle
  initial forever begin
    @(posedge clk);
    #1;
    rdy = rdy_mode ? ~rdy : 1'b1;
  end

  // TX monitor: handshake scoreboard, hold-stability and retry spacing
  initial begin : mon
    beat_t       b;
    logic        prev_val = 1'b0, hold_pend = 1'b0, hold_eop = 1'b0;
    logic [31:0] hold_dat = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (hold_pend) begin
        chk("hold_val", 32'(o_val), 32'd1);
        chk("hold_dat", o_dat, hold_dat);
        chk("hold_eop", 32'(o_eop), 32'(hold_eop));
      end
      if (o_val && !prev_val && eop_seen) gaps.push_back(cyc - t_eop - 1);
      if (o_val && rdy) begin
        if (qexp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_dword actual=%08h required=none", o_dat);
        end else begin
          b = qexp.pop_front();
          chk("tx_dat", o_dat, b.dat);
          chk("tx_eop", 32'(o_eop), 32'(b.eop));
        end
        if (o_eop) begin
          eop_cnt++;
          t_eop    = cyc;
          eop_seen = 1'b1;
        end
      end
      hold_pend = o_val && !rdy;
      hold_dat  = o_dat;
      hold_eop  = o_eop;
      prev_val  = o_val;
    end
  end

  task automatic run_vec(input vec_t v, input int k);
    int base;
    rdy_mode = v.toggle;
    gaps.delete();
    eop_seen = 1'b0;
    base     = eop_cnt;
    do_start();
    if (v.resp == R_NONE) repeat (MR) push_fis();
    wait_eop(base + 1);
    case (v.resp)
      R_DONE: begin
        repeat (v.delay) step();
        id_done = 1'b1;
        step();
        id_done = 1'b0;
      end
      R_D2H: begin
        i_val = 1'b1;
        i_dat = 32'h0051_0034;
        i_eop = 1'b0;
        push_fis();
        step();
        i_dat = 32'h0;
        i_eop = 1'b1;
        step();
        i_val = 1'b0;
        i_eop = 1'b0;
      end
      R_BAD: begin
        id_bad_crc = 1'b1;
        push_fis();
        step();
        id_bad_crc = 1'b0;
      end
      R_BOTH: begin
        id_done    = 1'b1;
        id_bad_crc = 1'b1;
        push_fis();
        step();
        id_done    = 1'b0;
        id_bad_crc = 1'b0;
      end
      default: wait_eop(base + MR + 1);
    endcase
    if (v.resp inside {R_D2H, R_BAD, R_BOTH}) begin
      wait_eop(base + 2);
      repeat (3) step();
      id_done = 1'b1;
      step();
      id_done = 1'b0;
    end
    wait_idle();
    chk($sformatf("v%0d_ok", k), 32'(identify_ok), 32'(v.exp_ok));
    chk($sformatf("v%0d_fail", k), 32'(identify_fail), 32'(v.exp_fail));
    chk($sformatf("v%0d_attempts", k), 32'(attempt_cnt), v.exp_att);
    chk($sformatf("v%0d_fis_left", k), qexp.size(), 0);
    if (v.resp == R_NONE) begin
      chk($sformatf("v%0d_retries", k), gaps.size(), MR);
      foreach (gaps[i]) chk($sformatf("v%0d_wait_cycles", k), gaps[i], TO);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int base;
    vecs[0] = '{1'b0, R_DONE, 30, 1'b1, 1'b0, 1};
    vecs[1] = '{1'b1, R_DONE, 5,  1'b1, 1'b0, 1};
    vecs[2] = '{1'b0, R_NONE, 0,  1'b0, 1'b1, MR + 1};
    vecs[3] = '{1'b0, R_D2H,  0,  1'b1, 1'b0, 2};
    vecs[4] = '{1'b1, R_BAD,  0,  1'b1, 1'b0, 2};
    vecs[5] = '{1'b0, R_BOTH, 0,  1'b1, 1'b0, 2};

    repeat (2) step();
    chk("rst_val", 32'(o_val), 32'd0);
    chk("rst_eop", 32'(o_eop), 32'd0);
    chk("rst_dat", o_dat, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ok", 32'(identify_ok), 32'd0);
    chk("rst_fail", 32'(identify_fail), 32'd0);
    chk("rst_attempts", 32'(attempt_cnt), 32'd0);
    reset      = 1'b0;
    link_ready = 1'b1;
    step();

    foreach (vecs[k]) run_vec(vecs[k], k);
    rdy_mode = 1'b0;

    // Stale id_done level from an earlier frame must not count as success
    id_done = 1'b1;
    repeat (3) step();
    gaps.delete();
    eop_seen = 1'b0;
    base     = eop_cnt;
    do_start();
    repeat (MR) push_fis();
    wait_eop(base + 1);
    repeat (50) step();
    chk("stale_ok", 32'(identify_ok), 32'd0);
    chk("stale_busy", 32'(busy), 32'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (2) step();
    chk("busy_start_attempts", 32'(attempt_cnt), 32'd1);
    wait_eop(base + MR + 1);
    wait_idle();
    chk("stale_fail", 32'(identify_fail), 32'd1);
    chk("stale_ok_end", 32'(identify_ok), 32'd0);
    chk("stale_attempts", 32'(attempt_cnt), MR + 1);
    chk("stale_fis_left", qexp.size(), 0);
    foreach (gaps[i]) chk("stale_wait_cycles", gaps[i], TO);
    id_done = 1'b0;

    // start without link is ignored and the previous result is held
    link_ready = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    chk("nolink_busy", 32'(busy), 32'd0);
    chk("nolink_val", 32'(o_val), 32'd0);
    chk("nolink_fail_held", 32'(identify_fail), 32'd1);
    chk("nolink_attempts_held", 32'(attempt_cnt), MR + 1);

    // Link drop while dword index 2 is on the bus
    link_ready = 1'b1;
    step();
    do_start();
    step();
    step();
    chk("drop_fis_left_idx2", qexp.size(), 3);
    link_ready = 1'b0;
    step();
    chk("drop_fail", 32'(identify_fail), 32'd1);
    chk("drop_val", 32'(o_val), 32'd0);
    chk("drop_busy", 32'(busy), 32'd0);
    chk("drop_ok", 32'(identify_ok), 32'd0);
    chk("drop_fis_left", qexp.size(), 2);
    qexp.delete();

    // Asynchronous reset in the middle of WAIT
    link_ready = 1'b1;
    step();
    base = eop_cnt;
    do_start();
    wait_eop(base + 1);
    repeat (10) step();
    chk("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ok", 32'(identify_ok), 32'd0);
    chk("arst_fail", 32'(identify_fail), 32'd0);
    chk("arst_attempts", 32'(attempt_cnt), 32'd0);
    chk("arst_val", 32'(o_val), 32'd0);
    chk("arst_eop", 32'(o_eop), 32'd0);
    chk("arst_dat", o_dat, 32'd0);
    step();
    step();
    reset = 1'b0;
    step();
    chk("arst_fis_left", qexp.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sata_identify_ctrl.md
Name: sata_identify_ctrl

Overview:
Sequences the IDENTIFY DEVICE exchange after link-up.
- Sends a Register H2D FIS (command 0xEC) to the transport-layer TX stream.
- Watches the RX stream and the identify parser's status flags (identify_done, bad_checksum).
- Retries on error or timeout, then reports success or failure to the host-side init logic.
- Sits between the link-status logic, the TX transport mux and sata_identify_parser.

Parameters:
TIMEOUT_CYCLES, 1_000_000, WAIT-state cycles before an attempt is declared timed out (>=2)
MAX_RETRIES, 3, extra attempts after the first failure (0 = single attempt)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
link_ready  in  1  link established (level)
start  in  1  one-cycle request to run IDENTIFY
o_dat  out  32  TX FIS dword
o_val  out  1  TX dword valid
o_eop  out  1  last dword of FIS
o_rdy  in  1  transport accepts dword when o_val & o_rdy
i_dat  in  32  RX dword (same stream feeding the parser)
i_val  in  1  RX dword valid
i_eop  in  1  RX last dword
id_done  in  1  parser identify_done
id_bad_crc  in  1  parser bad_checksum
busy  out  1  attempt in progress
identify_ok  out  1  IDENTIFY completed successfully (level)
identify_fail  out  1  all attempts exhausted or link lost (level)
attempt_cnt  out  $clog2(MAX_RETRIES+2)  attempts started since last start

Behaviour:
- Clock is clk. Reset is asynchronous and active-high on reset; all flops clear on posedge reset.
- Reset values: state IDLE; o_val=0, o_eop=0, o_dat=0; busy=0, identify_ok=0, identify_fail=0, attempt_cnt=0.
- States:
  - IDLE: wait for start & link_ready.
  - SEND: drive FIS, dword index 0..4.
  - WAIT: wait for result.
  - DONE: success.
  - FAIL: failure.
- IDLE/DONE/FAIL + (start & link_ready) -> SEND next cycle.
  - Clears identify_ok, identify_fail, dword index.
  - attempt_cnt<=1.
- start while busy is ignored. start with link_ready=0 is ignored.
- SEND: o_val=1, o_dat = FIS dword[index]; index advances only on o_val & o_rdy.
  - o_eop=1 on index 4.
  - Accepted eop -> WAIT; timeout counter cleared.
  - FIS dwords, little-endian bytes:
    - dw0 = 32'h00EC_8027 (type 0x27, C=1, cmd 0xEC, features 0).
    - dw1..dw4 = 0.
  - o_dat/o_eop must hold stable while o_val & !o_rdy.
- WAIT: the controller registers id_done and id_bad_crc and acts on their rising edges only, so stale levels from earlier frames are ignored.
  - Rising id_done -> DONE; identify_ok=1.
  - Error (rising id_bad_crc, or RX D2H Register FIS with ERR set) -> retry path.
    - RX D2H Register FIS: start-of-frame dword with i_dat[7:0]==0x34 and i_dat[16] (status ERR) =1.
    - SOF tracking: flag set at reset and after each i_val & i_eop.
  - Timeout counter increments each WAIT cycle; reaching TIMEOUT_CYCLES-1 -> retry path.
  - Simultaneous success edge and error in the same cycle -> error wins.
- Retry path:
  - If attempt_cnt <= MAX_RETRIES -> SEND; attempt_cnt+1; index 0.
  - Otherwise -> FAIL; identify_fail=1.
- busy=1 in SEND and WAIT only.
- link_ready low in SEND or WAIT -> FAIL immediately (no retry); o_val drops the next cycle. The TX FIS may be truncated without eop, because link reset flushes the transport.
- DONE/FAIL hold their outputs until the next accepted start or reset.
- Timeout counter width is $clog2(TIMEOUT_CYCLES); it must not wrap inside WAIT.

Optional Feature:
SATA_IDENTIFY_AUTOSTART_EN
- Defined: a rising edge of link_ready (registered internally) acts as start when in IDLE, DONE or FAIL. The explicit start input still works.
- Undefined: only start launches IDENTIFY; link_ready is used only as a qualifier and for abort.

Decomposition:
- Add to shared sata_defs.svh: REG_H2D_FIS (8'h27), REG_D2H_FIS (8'h34), ATA_CMD_IDENTIFY (8'hEC), alongside the existing DATA_FIS.
- State enum is local to the module.
- One natural sub-module, sata_h2d_fis_tx: a 5-dword FIS sequencer with valid/ready hold. It is reusable for later READ/WRITE DMA command issue.

Test Plan:
1. start with link_ready=1, o_rdy=1; pulse id_done 30 cycles after eop.
   -> dwords 0x00EC8027, 0, 0, 0, 0 with eop on the 5th.
   -> identify_ok=1, busy=0, attempt_cnt=1.
2. o_rdy toggling 1/0 every cycle during SEND.
   -> each dword held stable until accepted; exactly 5 accepted; no duplicates.
3. TIMEOUT_CYCLES=100, MAX_RETRIES=2, no response.
   -> FIS resent 3 times, each 100 WAIT cycles apart.
   -> identify_fail=1, attempt_cnt=3.
4. RX frame with dw0=0x0051_0034 (D2H, ERR) on first attempt; id_done on second.
   -> one retry, identify_ok=1, attempt_cnt=2.
5. id_done held high from a prior run before start; no new edge.
   -> stays in WAIT until timeout; no false success.
6. link_ready dropped mid-SEND at index 2.
   -> FAIL next cycle, o_val=0.
   -> Asynchronous reset asserted mid-WAIT returns all outputs to 0 immediately.
